// File: rtl/mem_req_ctrl.sv
// Memory-access controller sitting just upstream of the MEM stage.
// Takes one load/store per handshake and drives a word-aligned address, data and row command to MEM.
// Sub-word stores use read-modify-write.
// Returns extended load data and stalls the pipeline while an access is outstanding.
// Responses are registered, so they appear one cycle after the RESP/ERR state.
module mem_req_ctrl #(
  parameter int MISS_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic [31:0] address_o,
  output logic [31:0] data_o,
  output logic [1:0]  row_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_hit_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int CW = (MISS_TIMEOUT > 0) ? $clog2(MISS_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, RD, WR, RESP, ERR} state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          signed_q, signed_d;
  logic [1:0]    lane_q, lane_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [31:0]   address_q, address_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_data_q, resp_data_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          accept;
  logic          misaligned;
  logic          timeout;
  logic [CW-1:0] cnt_inc;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_val;
  logic [31:0]   merged;

  assign req_ready_o  = (state_q == IDLE) && !reset;
  assign stall_o      = (state_q != IDLE) || (req_valid_i && req_ready_o);
  assign accept       = req_valid_i && req_ready_o;
  assign address_o    = address_q;
  assign data_o       = data_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign err_o        = err_q;

  assign misaligned = (req_size_i == 2'b11) ||
                      ((req_size_i == 2'b01) && req_addr_i[0]) ||
                      ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));

  assign cnt_inc = cnt_q + CW'(1);
  assign timeout = (MISS_TIMEOUT != 0) && (cnt_inc == CW'(MISS_TIMEOUT));

  // Row command depends only on the state, so it drops to idle the cycle after any abort.
  always_comb begin
    row_o = 2'b00;
    if (state_q == RD) row_o = 2'b01;
    if (state_q == WR) row_o = 2'b10;
  end

  // Little-endian lane extraction with extension for loads, and lane merge for sub-word stores.
  always_comb begin
    byte_sel = mem_data_i[{lane_q, 3'b000} +: 8];
    half_sel = mem_data_i[{lane_q[1], 4'b0000} +: 16];
    load_val = mem_data_i;
    merged   = mem_data_i;
    case (size_q)
      2'b00: begin
        load_val = signed_q ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
        merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_val = signed_q ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
        merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
      end
      default: begin
        load_val = mem_data_i;
        merged   = mem_data_i;
      end
    endcase
  end

  // Next-state logic, request capture, wait counter and response generation.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    signed_d     = signed_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    address_d    = address_q;
    data_d       = data_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_data_d  = 32'b0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d      = req_we_i;
          size_d    = req_size_i;
          signed_d  = req_signed_i;
          lane_d    = req_addr_i[1:0];
          wdata_d   = req_wdata_i[15:0];
          address_d = {req_addr_i[31:2], 2'b00};
          data_d    = (req_we_i && (req_size_i == 2'b10)) ? req_wdata_i : 32'b0;
          rdata_d   = 32'b0;
          cnt_d     = '0;
          if (misaligned)                             state_d = ERR;
          else if (req_we_i && (req_size_i == 2'b10)) state_d = WR;
          else                                        state_d = RD;
        end
      end
      RD: begin
        if (mem_hit_i) begin
          cnt_d = '0;
          if (we_q) begin
            data_d  = merged;
            state_d = WR;
          end else begin
            rdata_d = load_val;
            state_d = RESP;
          end
        end else if (timeout) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WR: begin
        if (mem_hit_i)    state_d = RESP;
        else if (timeout) state_d = ERR;
        else              cnt_d   = cnt_inc;
      end
      RESP: begin
        resp_valid_d = 1'b1;
        resp_data_d  = rdata_q;
        state_d      = IDLE;
      end
      ERR: begin
        resp_valid_d = 1'b1;
        err_d        = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= 16'b0;
      address_q    <= 32'b0;
      data_q       <= 32'b0;
      rdata_q      <= 32'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      address_q    <= address_d;
      data_q       <= data_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: directed cases plus randomized loads/stores.
// Contains a behavioural MEM responder and a queue-based response/write scoreboard.
module tb_mem_req_ctrl;

  localparam int TO = 4;

  logic        clk          = 1'b0;
  logic        reset        = 1'b1;
  logic        req_valid_i  = 1'b0;
  logic        req_we_i     = 1'b0;
  logic [1:0]  req_size_i   = 2'b00;
  logic        req_signed_i = 1'b0;
  logic [31:0] req_addr_i   = 32'b0;
  logic [31:0] req_wdata_i  = 32'b0;
  logic [31:0] mem_data_i   = 32'b0;
  logic        mem_hit_i    = 1'b0;
  logic        req_ready_o;
  logic [31:0] address_o;
  logic [31:0] data_o;
  logic [1:0]  row_o;
  logic        resp_valid_o;
  logic [31:0] resp_data_o;
  logic        err_o;
  logic        stall_o;

  mem_req_ctrl #(.MISS_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_signed_i(req_signed_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .address_o(address_o), .data_o(data_o), .row_o(row_o),
    .mem_data_i(mem_data_i), .mem_hit_i(mem_hit_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
    .err_o(err_o), .stall_o(stall_o)
  );

  typedef struct { logic [31:0] data; logic err; int lat; } resp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

  resp_t       exp_q[$];
  wr_t         wr_q[$];
  int          accept_q[$];
  logic [31:0] env_mem [int];
  logic [31:0] ref_mem [int];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          rd_lat   = 0;
  int          wr_lat   = 0;

  function automatic logic [31:0] init_word(int idx);
    logic [31:0] v;
    v = idx;
    return (v * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] env_read(int idx);
    if (env_mem.exists(idx)) return env_mem[idx];
    return init_word(idx);
  endfunction

  function automatic logic [31:0] ref_read(int idx);
    if (ref_mem.exists(idx)) return ref_mem[idx];
    return init_word(idx);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: works out response, latency and any memory write from the access rules,
  // then drives the request and holds it until it is accepted.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int rl, input int wl);
    resp_t       e;
    wr_t         w;
    logic [31:0] word, mask, v;
    int          sh, budget, acc;
    bit          mis;
    mis    = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    word   = ref_read(int'(addr[31:2]));
    sh     = (size == 2'b00) ? 8 * addr[1:0] : 16 * addr[1];
    mask   = (size == 2'b00) ? (32'hFF << sh) : (32'hFFFF << sh);
    w.addr = {addr[31:2], 2'b00};
    w.data = (size == 2'b10) ? wdata : ((word & ~mask) | ((wdata << sh) & mask));
    e.data = 32'b0;
    e.err  = 1'b0;
    if (mis) begin
      e.err = 1'b1; e.lat = 2;
    end else if (!we) begin
      if (rl >= TO) begin
        e.err = 1'b1; e.lat = 2 + TO;
      end else begin
        v = (word >> sh) & ((size == 2'b00) ? 32'hFF : 32'hFFFF);
        if (size == 2'b10) v = word;
        else if (sgn && size == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
        else if (sgn && size == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
        e.data = v; e.lat = 3 + rl;
      end
    end else if (size == 2'b10) begin
      if (wl >= TO) begin
        e.err = 1'b1; e.lat = 2 + TO;
      end else begin
        wr_q.push_back(w); ref_mem[int'(addr[31:2])] = w.data; e.lat = 3 + wl;
      end
    end else begin
      if (rl >= TO) begin
        e.err = 1'b1; e.lat = 2 + TO;
      end else if (wl >= TO) begin
        e.err = 1'b1; e.lat = 3 + rl + TO;
      end else begin
        wr_q.push_back(w); ref_mem[int'(addr[31:2])] = w.data; e.lat = 4 + rl + wl;
      end
    end
    exp_q.push_back(e);
    rd_lat       = rl;
    wr_lat       = wl;
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_size_i   = size;
    req_signed_i = sgn;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!req_ready_o && budget < 50);
    if (!req_ready_o) begin
      checks++; failures++;
      $display("[TB] FAIL accept_wait: got ready=0 expected ready=1 within 50 cycles");
    end
    acc = cyc;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
    req_we_i    = 1'($urandom);
    while (cyc < acc + e.lat) begin
      @(posedge clk); #1;
    end
  endtask

  // Free-running clock and cycle counter used for latency measurement.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // MEM responder: hits after a programmed number of low cycles per row phase,
  // returns garbage data while not hitting, and checks every write it performs.
  logic [1:0] prev_row = 2'b00;
  int         row_cnt  = 0;
  always @(negedge clk) begin : responder
    int  lat;
    wr_t w;
    if (reset || row_o == 2'b00) begin
      mem_hit_i = 1'b0;
      row_cnt   = 0;
    end else begin
      if (row_o != prev_row) row_cnt = 0;
      else                   row_cnt++;
      lat       = (row_o == 2'b01) ? rd_lat : wr_lat;
      mem_hit_i = (row_cnt == lat);
    end
    mem_data_i = $urandom;
    if (mem_hit_i && row_o == 2'b01) mem_data_i = env_read(int'(address_o[31:2]));
    if (mem_hit_i && row_o == 2'b10) begin
      env_mem[int'(address_o[31:2])] = data_o;
      if (wr_q.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL unexpected_write: got write 0x%08h to 0x%08h expected none", data_o, address_o);
      end else begin
        w = wr_q.pop_front();
        checkOutput("write_addr", address_o, w.addr);
        checkOutput("write_data", data_o, w.data);
      end
    end
    prev_row = reset ? 2'b00 : row_o;
  end

  // Monitor: pops the scoreboard on every response and checks ready/stall every cycle.
  always @(negedge clk) begin : monitor
    resp_t e;
    int    a;
    logic  busy;
    if (reset) begin
      accept_q.delete();
    end else begin
      if (resp_valid_o) begin
        if (exp_q.size() == 0 || accept_q.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL unexpected_resp: got resp data 0x%08h err %0b expected none", resp_data_o, err_o);
        end else begin
          e = exp_q.pop_front();
          a = accept_q.pop_front();
          checkOutput("resp_data", resp_data_o, e.data);
          checkOutput("resp_err", 32'(err_o), 32'(e.err));
          checkOutput("resp_latency", cyc - a, e.lat);
        end
      end
      busy = (accept_q.size() != 0) && (cyc > accept_q[0]);
      checkOutput("req_ready", 32'(req_ready_o), 32'(!busy));
      checkOutput("stall", 32'(stall_o), 32'(busy || req_valid_i));
      if (req_valid_i && req_ready_o) accept_q.push_back(cyc);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset checks, directed cases, random traffic, mid-access reset.
  initial begin
    logic        we, sgn;
    logic [1:0]  size;
    logic [31:0] addr;
    int          rl, wl, n;
    env_mem[4] = 32'hA1B2_C3D4;
    ref_mem[4] = 32'hA1B2_C3D4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_row", 32'(row_o), 32'h0);
    checkOutput("reset_address", address_o, 32'h0);
    checkOutput("reset_data", data_o, 32'h0);
    checkOutput("reset_resp_valid", 32'(resp_valid_o), 32'h0);
    checkOutput("reset_resp_data", resp_data_o, 32'h0);
    checkOutput("reset_err", 32'(err_o), 32'h0);
    checkOutput("reset_ready", 32'(req_ready_o), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", 32'(req_ready_o), 32'h1);
    @(posedge clk); #1;

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0, 0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0, 0);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'h55, 0, 0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 0, 0);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0, 0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h13, 32'hBEEF, 0, 0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 5, 0);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h15, 32'hAB, 4, 0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h16, 32'h1234, 1, 4);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h18, 32'hCAFE_F00D, 0, 2);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 3, 0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 3, 0);

    for (int i = 0; i < 150; i++) begin
      we   = 1'($urandom);
      sgn  = 1'($urandom);
      size = 2'($urandom_range(0, 3));
      addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'b01) addr[0]   = 1'b0;
        if (size == 2'b10) addr[1:0] = 2'b00;
      end
      rl = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 6);
      wl = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 6);
      applyStimulus(we, size, sgn, addr, $urandom, rl, wl);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    repeat (4) begin
      @(posedge clk); #1;
    end

    rd_lat       = 0;
    wr_lat       = 100;
    req_valid_i  = 1'b1;
    req_we_i     = 1'b1;
    req_size_i   = 2'b10;
    req_addr_i   = 32'h20;
    req_wdata_i  = 32'h1357_9BDF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready_o && n < 50);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    checkOutput("row_write_before_reset", 32'(row_o), 32'h2);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("ready_during_reset", 32'(req_ready_o), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("row_after_reset", 32'(row_o), 32'h0);
    checkOutput("resp_valid_after_reset", 32'(resp_valid_o), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("no_resp_after_abort", 32'(resp_valid_o), 32'h0);
      checkOutput("row_idle_after_abort", 32'(row_o), 32'h0);
      checkOutput("ready_after_abort", 32'(req_ready_o), 32'h1);
    end

    checkOutput("pending_responses", 32'(exp_q.size()), 32'h0);
    checkOutput("pending_writes", 32'(wr_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
